// File: rtl/alu_exec_pkg.sv
// Shared types and constants for the execute stage: opcodes, regfile write
// and flag write records, and the single-cycle ALU function.
package alu_exec_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADR_W  = 3;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SHAMT_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MOV  = 4'd7,
    OP_CMP  = 4'd8,
    OP_CMPA = 4'd9,
    OP_MUL  = 4'd10,
    OP_NOP  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic              ena;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } signal_wr_reg;

  typedef struct packed {
    logic ena;
    logic ravno;
    logic bolshe;
    logic menshe;
    logic ena_ra;
    logic rav_adr;
  } signal_flag_wr_alu;

  // Result of the single-cycle write-back ops; other opcodes give zero.
  function automatic logic [DATA_W-1:0] alu_calc(
    input alu_op_e           op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] res;
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[SHAMT_W-1:0];
      OP_SHR:  res = a >> b[SHAMT_W-1:0];
      OP_MOV:  res = b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_exec_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle, 16 cycles,
// low 16 bits of the product presented alongside the final-iteration done.
module alu_mul_seq
  import alu_exec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic              run,
  input  logic              flush,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done_c,
  output logic [DATA_W-1:0] product_c
);

  localparam int unsigned CNT_W = 4;

  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] addend_c;
  logic [DATA_W-1:0] acc_nxt_c;

  assign addend_c  = mplier_q[0] ? mcand_q : '0;
  assign acc_nxt_c = acc_q + addend_c;
  assign product_c = acc_nxt_c;
  assign done_c    = run & ~flush & (cnt_q == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (run) begin
      // An abort only needs the counter parked; operands are reloaded on start.
      if (flush) begin
        cnt_q <= '0;
      end else begin
        acc_q    <= acc_nxt_c;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage feeding the register file: registered single-cycle ALU ops,
// compare flags, and a stalling 16-cycle multiply.
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ADR_W-1:0]  dst_i,
  output logic              wr_ena_o,
  output logic [ADR_W-1:0]  wr_adr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              flag_ena_o,
  output logic              flag_ravno_o,
  output logic              flag_bolshe_o,
  output logic              flag_menshe_o,
  output logic              flag_ena_ra_o,
  output logic              flag_rav_adr_o,
  output logic              busy_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]        state_q, state_d;
  signal_wr_reg      wr_q, wr_d;
  signal_flag_wr_alu flag_q, flag_d;
  logic [ADR_W-1:0]  dst_q, dst_d;
  alu_op_e           op_c;
  logic              accept_c;
  logic              mul_start_c;
  logic              mul_run_c;
  logic              mul_done_c;
  logic [DATA_W-1:0] mul_product_c;
  logic [DATA_W-1:0] alu_res_c;

  assign op_c      = alu_op_e'(op_i);
  assign accept_c  = valid_i & (state_q == ST_IDLE) & ~flush_i;
  assign mul_run_c = (state_q == ST_MUL);
  assign alu_res_c = alu_calc(op_c, a_i, b_i);

  alu_mul_seq u_mul (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .start     (mul_start_c),
    .run       (mul_run_c),
    .flush     (flush_i),
    .a         (a_i),
    .b         (b_i),
    .done_c    (mul_done_c),
    .product_c (mul_product_c)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wr_q    <= '0;
      flag_q  <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      flag_q  <= flag_d;
      dst_q   <= dst_d;
    end
  end

  // Next state and next output records; strobes default low, payloads hold.
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    mul_start_c = 1'b0;
    wr_d        = wr_q;
    wr_d.ena    = 1'b0;
    flag_d        = flag_q;
    flag_d.ena    = 1'b0;
    flag_d.ena_ra = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          case (op_c)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV: begin
              wr_d.ena  = 1'b1;
              wr_d.adr  = dst_i;
              wr_d.data = alu_res_c;
            end
            OP_CMP: begin
              flag_d.ena    = 1'b1;
              flag_d.ravno  = (a_i == b_i);
              flag_d.bolshe = (a_i > b_i);
              flag_d.menshe = (a_i < b_i);
            end
            OP_CMPA: begin
              flag_d.ena_ra  = 1'b1;
              flag_d.rav_adr = (a_i == b_i);
            end
            OP_MUL: begin
              state_d     = ST_MUL;
              mul_start_c = 1'b1;
              dst_d       = dst_i;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (mul_done_c) begin
          state_d   = ST_IDLE;
          wr_d.ena  = 1'b1;
          wr_d.adr  = dst_q;
          wr_d.data = mul_product_c;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready_o        = (state_q == ST_IDLE);
  assign busy_o         = (state_q == ST_MUL);
  assign wr_ena_o       = wr_q.ena;
  assign wr_adr_o       = wr_q.adr;
  assign wr_data_o      = wr_q.data;
  assign flag_ena_o     = flag_q.ena;
  assign flag_ravno_o   = flag_q.ravno;
  assign flag_bolshe_o  = flag_q.bolshe;
  assign flag_menshe_o  = flag_q.menshe;
  assign flag_ena_ra_o  = flag_q.ena_ra;
  assign flag_rav_adr_o = flag_q.rav_adr;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios plus random traffic,
// all compared every cycle against a transaction-level reference model.
module tb_alu_exec;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [3:0]  op_i;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic [2:0]  dst_i;
  logic        wr_ena_o;
  logic [2:0]  wr_adr_o;
  logic [15:0] wr_data_o;
  logic        flag_ena_o;
  logic        flag_ravno_o;
  logic        flag_bolshe_o;
  logic        flag_menshe_o;
  logic        flag_ena_ra_o;
  logic        flag_rav_adr_o;
  logic        busy_o;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  alu_exec dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .flush_i        (flush_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .dst_i          (dst_i),
    .wr_ena_o       (wr_ena_o),
    .wr_adr_o       (wr_adr_o),
    .wr_data_o      (wr_data_o),
    .flag_ena_o     (flag_ena_o),
    .flag_ravno_o   (flag_ravno_o),
    .flag_bolshe_o  (flag_bolshe_o),
    .flag_menshe_o  (flag_menshe_o),
    .flag_ena_ra_o  (flag_ena_ra_o),
    .flag_rav_adr_o (flag_rav_adr_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model state: expected outputs plus pending multiply.
  logic        m_busy;
  int          m_left;
  logic [15:0] m_prod;
  logic [2:0]  m_dst;
  logic        e_wr_ena, e_fe, e_rv, e_bo, e_me, e_era, e_ra;
  logic [2:0]  e_wr_adr;
  logic [15:0] e_wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    longint unsigned x, y, r;
    x = a;
    y = b;
    case (op)
      0: r = x + y;
      1: r = x + 65536 - y;
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = x * (longint'(1) << (y % 16));
      6: r = x / (longint'(1) << (y % 16));
      default: r = y;
    endcase
    return 16'(r % 65536);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_left = 0; m_prod = '0; m_dst = '0;
    e_wr_ena = 0; e_wr_adr = '0; e_wr_data = '0;
    e_fe = 0; e_rv = 0; e_bo = 0; e_me = 0; e_era = 0; e_ra = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_next();
    e_wr_ena = 0; e_fe = 0; e_era = 0;
    if (!m_busy) begin
      if (valid_i && !flush_i) begin
        if (op_i <= 4'd7) begin
          e_wr_ena = 1; e_wr_adr = dst_i; e_wr_data = ref_alu(int'(op_i), a_i, b_i);
        end else if (op_i == 4'd8) begin
          e_fe = 1; e_rv = (a_i == b_i); e_bo = (a_i > b_i); e_me = (a_i < b_i);
        end else if (op_i == 4'd9) begin
          e_era = 1; e_ra = (a_i == b_i);
        end else if (op_i == 4'd10) begin
          m_busy = 1; m_left = 16; m_dst = dst_i;
          m_prod = 16'((longint'(a_i) * longint'(b_i)) % 65536);
        end
      end
    end else if (flush_i) begin
      m_busy = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; e_wr_ena = 1; e_wr_adr = m_dst; e_wr_data = m_prod;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"},   32'(ready_o),        32'(!m_busy));
    chk({tag, ".busy"},    32'(busy_o),         32'(m_busy));
    chk({tag, ".wr_ena"},  32'(wr_ena_o),       32'(e_wr_ena));
    chk({tag, ".wr_adr"},  32'(wr_adr_o),       32'(e_wr_adr));
    chk({tag, ".wr_data"}, 32'(wr_data_o),      32'(e_wr_data));
    chk({tag, ".fe"},      32'(flag_ena_o),     32'(e_fe));
    chk({tag, ".ravno"},   32'(flag_ravno_o),   32'(e_rv));
    chk({tag, ".bolshe"},  32'(flag_bolshe_o),  32'(e_bo));
    chk({tag, ".menshe"},  32'(flag_menshe_o),  32'(e_me));
    chk({tag, ".era"},     32'(flag_ena_ra_o),  32'(e_era));
    chk({tag, ".rav_adr"}, 32'(flag_rav_adr_o), 32'(e_ra));
  endtask

  task automatic drive(input logic v, input int op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, input logic f);
    valid_i = v; op_i = 4'(op); a_i = a; b_i = b; dst_i = d; flush_i = f;
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    for (int i = 0; i < n; i++) step("idle");
  endtask

  initial begin
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    idle(1);

    // ADD wraps
    drive(1'b1, 0, 16'hFFFF, 16'h0002, 3'd3, 1'b0);
    step("add");
    chk("add.data_const", 32'(wr_data_o), 32'h0001);
    chk("add.adr_const", 32'(wr_adr_o), 32'd3);
    idle(1);

    drive(1'b1, 8, 16'd5, 16'd9, 3'd1, 1'b0);
    step("cmp");
    chk("cmp.menshe_const", 32'(flag_menshe_o), 32'd1);
    drive(1'b1, 9, 16'h0040, 16'h0040, 3'd1, 1'b0);
    step("cmpa");
    chk("cmpa.rav_const", 32'(flag_rav_adr_o), 32'd1);
    idle(1);

    // MUL with a second op held throughout the stall
    drive(1'b1, 10, 16'h0123, 16'h0010, 3'd6, 1'b0);
    step("mul_acc");
    drive(1'b1, 0, 16'h0010, 16'h0020, 3'd2, 1'b0);
    for (int i = 0; i < 16; i++) step("mul_run");
    chk("mul.data_const", 32'(wr_data_o), 32'h1230);
    step("mul_next");
    chk("mul_next.data_const", 32'(wr_data_o), 32'h0030);
    idle(1);

    drive(1'b1, 10, 16'hFFFF, 16'hFFFF, 3'd7, 1'b0);
    step("mulff_acc");
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 16; i++) step("mulff_run");
    chk("mulff.data_const", 32'(wr_data_o), 32'h0001);
    drive(1'b1, 5, 16'h8001, 16'h0011, 3'd4, 1'b0);
    step("shl");
    chk("shl.data_const", 32'(wr_data_o), 32'h0002);
    idle(1);

    // Flush at the 8th iteration
    drive(1'b1, 10, 16'h1234, 16'h0055, 3'd5, 1'b0);
    step("flush_acc");
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 7; i++) step("flush_run");
    drive(1'b0, 0, '0, '0, '0, 1'b1);
    step("flush_hit");
    idle(17);

    // Flush on the final iteration edge
    drive(1'b1, 10, 16'h0003, 16'h0005, 3'd2, 1'b0);
    step("flush16_acc");
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 15; i++) step("flush16_run");
    drive(1'b0, 0, '0, '0, '0, 1'b1);
    step("flush16_hit");
    idle(2);

    // Reset mid-multiply
    drive(1'b1, 10, 16'h00AA, 16'h0033, 3'd1, 1'b0);
    step("rstm_acc");
    drive(1'b0, 0, '0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step("rstm_run");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rstm_reset");
    @(posedge clk_i); #1;
    rst_n = 1'b1;
    idle(20);

    drive(1'b1, 0, 16'h0001, 16'h0001, 3'd1, 1'b1);
    step("flush_idle");
    drive(1'b1, 12, 16'h0001, 16'h0001, 3'd1, 1'b0);
    step("nop12");
    idle(1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)), ra, rb,
            3'($urandom), $urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
